// File: rtl/pio_cmd_decoder.sv
// Decodes HPS PIO instructions into image RAM writes or engine commands, with an enable/done handshake.
// All outputs are registered. Write strobe at cycle 3 and done at cycle 4 after the enable rise; NOP/CLEAR done at cycle 3.
module pio_cmd_decoder #(
  parameter int ADDR_W         = 15,
  parameter int DATA_W         = 8,
  parameter int IMG_PIXELS     = 19200,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [28:0]       pio_instruct,
  input  logic              pio_enable,
  output logic [3:0]        pio_flags,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              eng_start,
  output logic [2:0]        eng_mode,
  input  logic              eng_ready,
  input  logic              eng_done,
  input  logic              eng_error
);

  localparam int INSTR_W = 3 + ADDR_W + DATA_W;
  localparam int CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_MEM_WR, S_ENG_REQ, S_ENG_WAIT, S_COMPLETE
  } state_t;

  state_t               state_q, state_d;
  logic                 en_q;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [CNT_W-1:0]     wdog_q, wdog_d;
  logic                 error_q, error_d;
  logic                 timeout_q, timeout_d;
  logic                 eng_start_q, eng_start_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 mem_wr_en_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [DATA_W-1:0]    mem_wr_data_q;

  logic                 rise;
  logic                 wdog_expired;
  logic                 addr_ok;
  logic [2:0]           opcode;
  logic [ADDR_W-1:0]    instr_addr;
  logic [DATA_W-1:0]    instr_data;
  logic                 unused_rsvd;

  assign unused_rsvd  = ^pio_instruct[28:INSTR_W];
  assign opcode       = instr_q[2:0];
  assign instr_addr   = instr_q[3 +: ADDR_W];
  assign instr_data   = instr_q[3 + ADDR_W +: DATA_W];
  assign rise         = pio_enable & ~en_q;
  assign wdog_expired = (wdog_q == WDOG_LAST);
  assign addr_ok      = (32'(instr_addr) < IMG_PIXELS);

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    wdog_d      = wdog_q;
    error_d     = error_q;
    timeout_d   = timeout_q;
    eng_start_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          instr_d   = pio_instruct[INSTR_W-1:0];
          error_d   = 1'b0;
          timeout_d = 1'b0;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        wdog_d = '0;
        case (opcode)
          OP_NOP, OP_CLEAR: state_d = S_COMPLETE;
          OP_WRITE: begin
            if (addr_ok) begin
              state_d = S_MEM_WR;
            end else begin
              error_d = 1'b1;
              state_d = S_COMPLETE;
            end
          end
          default: begin
            eng_start_d = 1'b1;
            state_d     = S_ENG_REQ;
          end
        endcase
      end
      S_MEM_WR: state_d = S_COMPLETE;
      S_ENG_REQ: begin
        // eng_start_q is high for the whole of ENG_REQ, so eng_ready alone is the handshake
        wdog_d = wdog_q + CNT_W'(1);
        if (wdog_expired) begin
          error_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_COMPLETE;
        end else if (eng_ready) begin
          state_d = S_ENG_WAIT;
        end else begin
          eng_start_d = 1'b1;
        end
      end
      S_ENG_WAIT: begin
        wdog_d = wdog_q + CNT_W'(1);
        if (eng_done) begin
          error_d = eng_error;
          state_d = S_COMPLETE;
        end else if (wdog_expired) begin
          error_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        if (!pio_enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Flags lag the state by one cycle; the rise term makes busy visible immediately after acceptance.
  assign done_d = (state_q == S_COMPLETE);
  assign busy_d = (state_q == S_DECODE) || (state_q == S_MEM_WR) || (state_q == S_ENG_REQ) ||
                  (state_q == S_ENG_WAIT) || ((state_q == S_IDLE) && rise);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      en_q          <= 1'b1;
      instr_q       <= '0;
      wdog_q        <= '0;
      error_q       <= 1'b0;
      timeout_q     <= 1'b0;
      eng_start_q   <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= pio_enable;
      instr_q     <= instr_d;
      wdog_q      <= wdog_d;
      error_q     <= error_d;
      timeout_q   <= timeout_d;
      eng_start_q <= eng_start_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      mem_wr_en_q <= (state_q == S_MEM_WR);
      if (state_q == S_MEM_WR) begin
        mem_addr_q    <= instr_addr;
        mem_wr_data_q <= instr_data;
      end
    end
  end

  assign pio_flags   = {timeout_q, busy_q, error_q, done_q};
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign eng_start   = eng_start_q;
  assign eng_mode    = instr_q[2:0];

endmodule

// File: tb/tb_pio_cmd_decoder.sv
// Directed bench for pio_cmd_decoder: main instance with the default watchdog, second instance with a 16-cycle watchdog.
module tb_pio_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [28:0] pio_instruct;
  logic        pio_enable;
  logic        eng_ready, eng_done, eng_error;

  logic [3:0]  pio_flags,   pio_flags_w;
  logic        mem_wr_en,   mem_wr_en_w;
  logic [14:0] mem_addr,    mem_addr_w;
  logic [7:0]  mem_wr_data, mem_wr_data_w;
  logic        eng_start,   eng_start_w;
  logic [2:0]  eng_mode,    eng_mode_w;

  int n_total = 0;
  int n_pass  = 0;
  int wr_cnt  = 0;
  int st_cnt  = 0;
  int st_cnt_w = 0;

  always #5 clk = ~clk;

  pio_cmd_decoder u_dut (
    .clk(clk), .reset_n(reset_n), .pio_instruct(pio_instruct), .pio_enable(pio_enable),
    .pio_flags(pio_flags), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .eng_start(eng_start), .eng_mode(eng_mode), .eng_ready(eng_ready), .eng_done(eng_done),
    .eng_error(eng_error)
  );

  pio_cmd_decoder #(.TIMEOUT_CYCLES(16)) u_dut_wd (
    .clk(clk), .reset_n(reset_n), .pio_instruct(pio_instruct), .pio_enable(pio_enable),
    .pio_flags(pio_flags_w), .mem_wr_en(mem_wr_en_w), .mem_addr(mem_addr_w), .mem_wr_data(mem_wr_data_w),
    .eng_start(eng_start_w), .eng_mode(eng_mode_w), .eng_ready(eng_ready), .eng_done(eng_done),
    .eng_error(eng_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; afterwards the bench sits 1ns past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_wr_en)   wr_cnt++;
    if (eng_start)   st_cnt++;
    if (eng_start_w) st_cnt_w++;
  endtask

  function automatic logic [28:0] mk(input logic [2:0] op, input logic [14:0] addr, input logic [7:0] data);
    return {3'b000, data, addr, op};
  endfunction

  // Enable is high for cycle 0 only; returns in cycle 1.
  task automatic issue(input logic [28:0] ins);
    pio_instruct = ins;
    pio_enable   = 1'b1;
    tick();
    pio_enable   = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    pio_enable   = 1'b1;
    pio_instruct = mk(3'd1, 15'd5, 8'h3C);
    eng_ready    = 1'b0;
    eng_done     = 1'b0;
    eng_error    = 1'b0;
    #1;
    chk("rst_flags",     32'(pio_flags),   32'h0);
    chk("rst_wr_en",     32'(mem_wr_en),   32'h0);
    chk("rst_addr",      32'(mem_addr),    32'h0);
    chk("rst_data",      32'(mem_wr_data), 32'h0);
    chk("rst_eng_start", 32'(eng_start),   32'h0);
    chk("rst_eng_mode",  32'(eng_mode),    32'h0);
    repeat (3) tick();
    reset_n = 1'b1;
    wr_cnt = 0; st_cnt = 0;
    repeat (6) tick();
    chk("held_en_no_wr",    32'(wr_cnt),    32'h0);
    chk("held_en_no_start", 32'(st_cnt),    32'h0);
    chk("held_en_flags",    32'(pio_flags), 32'h0);
    pio_enable = 1'b0;
    tick();

    // WRITE data 0xA5 to address 100
    wr_cnt = 0;
    issue(mk(3'd1, 15'd100, 8'hA5));
    chk("wr_c1_busy", 32'(pio_flags), 32'h4);
    tick(); tick();
    chk("wr_c3_en",   32'(mem_wr_en),   32'h1);
    chk("wr_c3_addr", 32'(mem_addr),    32'd100);
    chk("wr_c3_data", 32'(mem_wr_data), 32'hA5);
    tick();
    chk("wr_c4_flags", 32'(pio_flags), 32'h1);
    chk("wr_c4_en",    32'(mem_wr_en), 32'h0);
    tick();
    chk("wr_done_1cyc", 32'(pio_flags), 32'h0);
    chk("wr_count",     32'(wr_cnt),    32'h1);

    // NOP with enable held: done stays up until enable drops
    pio_instruct = mk(3'd0, 15'd0, 8'h00);
    pio_enable   = 1'b1;
    tick(); tick(); tick();
    chk("nop_c3_flags", 32'(pio_flags), 32'h1);
    tick(); tick();
    chk("nop_hold", 32'(pio_flags), 32'h1);
    pio_enable = 1'b0;
    tick(); tick();
    chk("nop_release", 32'(pio_flags), 32'h0);

    // last valid pixel address
    issue(mk(3'd1, 15'd19199, 8'h5A));
    tick(); tick();
    chk("wr_max_en",   32'(mem_wr_en), 32'h1);
    chk("wr_max_addr", 32'(mem_addr),  32'd19199);
    tick(); tick();

    // first invalid address: error, no write, address output holds
    wr_cnt = 0;
    issue(mk(3'd1, 15'd19200, 8'h11));
    tick(); tick();
    chk("bad_addr_flags", 32'(pio_flags), 32'h3);
    tick();
    chk("bad_addr_err_persist", 32'(pio_flags), 32'h2);
    chk("bad_addr_no_wr",       32'(wr_cnt),    32'h0);
    chk("bad_addr_hold",        32'(mem_addr),  32'd19199);

    // CLEAR wipes the error
    issue(mk(3'd7, 15'd0, 8'h00));
    chk("clr_c1_flags", 32'(pio_flags), 32'h4);
    tick(); tick();
    chk("clr_c3_flags", 32'(pio_flags), 32'h1);
    tick();

    // ENGINE op 3: ready after 5 cycles, done 20 cycles after ready; a stray enable pulse while busy
    wr_cnt = 0; st_cnt = 0;
    issue(mk(3'd3, 15'd0, 8'h00));
    tick();
    chk("eng_c2_start", 32'(eng_start), 32'h1);
    chk("eng_c2_mode",  32'(eng_mode),  32'h3);
    tick();
    pio_instruct = mk(3'd1, 15'd7, 8'hFF);
    pio_enable   = 1'b1;
    tick();
    pio_enable   = 1'b0;
    tick(); tick(); tick();
    chk("eng_start_at_ready", 32'(eng_start), 32'h1);
    chk("eng_busy_at_ready",  32'(pio_flags), 32'h4);
    eng_ready = 1'b1;
    tick();
    eng_ready = 1'b0;
    chk("eng_start_dropped", 32'(eng_start), 32'h0);
    chk("eng_start_cycles",  32'(st_cnt),    32'd6);
    repeat (19) tick();
    chk("eng_wait_busy", 32'(pio_flags),   32'h4);
    chk("wd_eng_tmo",    32'(pio_flags_w), 32'hA);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    tick();
    chk("eng_done_flags",   32'(pio_flags), 32'h1);
    chk("busy_pulse_no_wr", 32'(wr_cnt),    32'h0);

    // watchdog instance: engine never responds
    st_cnt_w = 0;
    issue(mk(3'd5, 15'd0, 8'h00));
    repeat (16) tick();
    chk("tmo_last_req", 32'(eng_start_w), 32'h1);
    tick();
    chk("tmo_start_low", 32'(eng_start_w),    32'h0);
    chk("tmo_bit",       32'(pio_flags_w[3]), 32'h1);
    chk("tmo_req_len",   32'(st_cnt_w),       32'd16);
    tick();
    chk("tmo_flags", 32'(pio_flags_w), 32'hB);
    eng_ready = 1'b1;
    tick();
    eng_ready = 1'b0;
    eng_done  = 1'b1;
    tick();
    eng_done  = 1'b0;
    tick();
    chk("main_recover_flags", 32'(pio_flags), 32'h1);

    // eng_done (with error) on the watchdog's final cycle beats the timeout
    issue(mk(3'd2, 15'd0, 8'h00));
    tick();
    eng_ready = 1'b1;
    tick();
    eng_ready = 1'b0;
    repeat (14) tick();
    eng_done  = 1'b1;
    eng_error = 1'b1;
    tick();
    eng_done  = 1'b0;
    eng_error = 1'b0;
    tick();
    chk("race_wd_flags",   32'(pio_flags_w), 32'h3);
    chk("race_main_flags", 32'(pio_flags),   32'h3);

    // reset in ENG_WAIT aborts everything at once
    issue(mk(3'd4, 15'd0, 8'h00));
    tick();
    eng_ready = 1'b1;
    tick();
    eng_ready = 1'b0;
    tick(); tick();
    chk("pre_rst_busy", 32'(pio_flags), 32'h4);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_flags", 32'(pio_flags),   32'h0);
    chk("mid_rst_addr",  32'(mem_addr),    32'h0);
    chk("mid_rst_mode",  32'(eng_mode),    32'h0);
    chk("mid_rst_wd",    32'(pio_flags_w), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    issue(mk(3'd0, 15'd0, 8'h00));
    tick(); tick();
    chk("post_rst_nop",    32'(pio_flags),   32'h1);
    chk("post_rst_nop_wd", 32'(pio_flags_w), 32'h1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
